// File: rtl/prio_encoder_hs.sv
// rtl/prio_encoder_hs.sv - registered N-to-log2(N) priority encoder, fixed or round-robin, valid/ready output
module prio_encoder_hs #(
    parameter int N    = 8,
    parameter int MODE = 0,
    localparam int W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_multi
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] win;
    logic         load_en;
    logic         any_req;
    logic         multi;

    // Position k steps below p in the descending, wrapping search order.
    function automatic int rr_pos(input logic [W-1:0] p, input int k);
        int pi;
        pi = int'(p);
        return (pi >= k) ? (pi - k) : (pi + N - k);
    endfunction

    assign load_en = (state_q == EMPTY) || out_ready;
    assign any_req = |req;
    assign multi   = |(req & (req - N'(1)));
    assign out_valid = (state_q == FULL);

    always_comb begin
        win = '0;
        if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) win = W'(i);
            end
        end else begin
            // Walk from the far end so the entry closest to ptr overrides.
            for (int k = N - 1; k >= 0; k--) begin
                if (req[rr_pos(ptr_q, k)]) win = W'(rr_pos(ptr_q, k));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            if (any_req) begin
                state_d = FULL;
                if (MODE != 0) ptr_d = (win == '0) ? W'(N - 1) : win - W'(1);
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= W'(N - 1);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx    <= '0;
            out_onehot <= '0;
            out_multi  <= 1'b0;
        end else if (load_en && any_req) begin
            out_idx    <= win;
            out_onehot <= N'(1) << win;
            out_multi  <= multi;
        end
    end

endmodule

// File: tb/tb_prio_encoder_hs.sv
// tb/tb_prio_encoder_hs.sv - directed checks of fixed-priority and round-robin encoder instances
module tb_prio_encoder_hs;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] req4 = '0;
    logic [4:0] req5 = '0;

    logic       v0, m0, v1, m1, v2, m2;
    logic [1:0] i0, i1;
    logic [2:0] i2;
    logic [3:0] h0, h1;
    logic [4:0] h2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prio_encoder_hs #(.N(4), .MODE(0)) u_fixed4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .out_ready(out_ready),
        .out_valid(v0), .out_idx(i0), .out_onehot(h0), .out_multi(m0)
    );

    prio_encoder_hs #(.N(4), .MODE(1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .out_ready(out_ready),
        .out_valid(v1), .out_idx(i1), .out_onehot(h1), .out_multi(m1)
    );

    prio_encoder_hs #(.N(5), .MODE(1)) u_rr5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .out_ready(out_ready),
        .out_valid(v2), .out_idx(i2), .out_onehot(h2), .out_multi(m2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    int rr4_exp[6]  = '{3, 2, 1, 0, 3, 2};
    int sp4_exp[4]  = '{2, 0, 2, 0};
    int sp5_exp[4]  = '{4, 0, 4, 0};

    initial begin
        // Reset held with all requests active
        req4 = 4'b1111;
        req5 = 5'b11111;
        tick();
        tick();
        check("rst_valid", int'(v0), 0);
        check("rst_idx", int'(i0), 0);
        check("rst_onehot", int'(h0), 0);
        check("rst_multi", int'(m0), 0);
        check("rst_valid_rr", int'(v1), 0);
        req4 = '0;
        req5 = '0;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("idle_valid", int'(v0), 0);
        end

        // Fixed priority
        out_ready = 1'b1;
        req4 = 4'b0110;
        tick();
        check("fp_valid", int'(v0), 1);
        check("fp_idx", int'(i0), 2);
        check("fp_onehot", int'(h0), 4);
        check("fp_multi", int'(m0), 1);
        req4 = 4'b0001;
        tick();
        check("fp_idx_low", int'(i0), 0);
        check("fp_multi_low", int'(m0), 0);
        check("fp_onehot_low", int'(h0), 1);

        // Backpressure
        req4 = 4'b0100;
        tick();
        check("bp_load", int'(i0), 2);
        out_ready = 1'b0;
        req4 = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_hold_idx", int'(i0), 2);
            check("bp_hold_valid", int'(v0), 1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_idx", int'(i0), 3);
        req4 = '0;
        tick();
        check("bp_drain_valid", int'(v0), 0);

        // Round-robin fairness, all requests
        reset_pulse();
        req4 = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("rr_full_idx", int'(i1), rr4_exp[c]);
            check("rr_full_valid", int'(v1), 1);
        end

        // Round-robin sparse, power of two and not
        req4 = '0;
        tick();
        reset_pulse();
        req4 = 4'b0101;
        req5 = 5'b10001;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("rr_sparse4_idx", int'(i1), sp4_exp[c]);
            check("rr_sparse5_idx", int'(i2), sp5_exp[c]);
        end
        check("rr_sparse5_onehot", int'(h2), 1);
        check("rr_sparse5_multi", int'(m2), 1);

        // Async reset while a result is held
        req4 = '0;
        req5 = '0;
        tick();
        reset_pulse();
        req4 = 4'b1111;
        tick();
        check("ar_first", int'(i1), 3);
        tick();
        check("ar_second", int'(i1), 2);
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid_drop", int'(v1), 0);
        check("ar_idx_clear", int'(i1), 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("ar_restart_idx", int'(i1), 3);
        check("ar_restart_valid", int'(v1), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
